uart_tx_frame: RTL and testbench

- Serialising transmitter that sits directly downstream of the baud clock generator.
- Accepts one parallel character from the host/FIFO side and drives the serial tx line: start bit, 7 or 8 data bits LSB first, optional parity, one stop bit.
- Bit timing is taken solely from the generator's xmit_pulse, which is a one-clk strobe once per bit period.
- A single holding register allows back-to-back frames with no idle gap.

---
 rtl/uart_tx_frame_if.sv | 37 +++
 rtl/uart_tx_frame.sv | 180 ++++++++++++++++++
 tb/tb_uart_tx_frame.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_frame_if.sv
// Bundle of host-side and baud-side signals for the UART frame transmitter.
// The master drives characters, configuration and the bit strobe; the slave returns the line and status.
interface uart_tx_frame_if;
    logic       xmit_pulse;
    logic [7:0] tx_data;
    logic       data_en;
    logic       bit8;
    logic       parity_en;
    logic       odd_n_even;
    logic       tx;
    logic       tx_rdy;
    logic       tx_busy;

    modport master (
        output xmit_pulse,
        output tx_data,
        output data_en,
        output bit8,
        output parity_en,
        output odd_n_even,
        input  tx,
        input  tx_rdy,
        input  tx_busy
    );

    modport slave (
        input  xmit_pulse,
        input  tx_data,
        input  data_en,
        input  bit8,
        input  parity_en,
        input  odd_n_even,
        output tx,
        output tx_rdy,
        output tx_busy
    );
endinterface

// File: rtl/uart_tx_frame.sv
// UART frame serialiser: start bit, 7/8 data bits LSB first, optional parity, one stop bit.
// Bit timing comes only from xmit_pulse; a single holding register allows gap-free back-to-back frames.
module uart_tx_frame #(
    parameter bit TXRDY_EARLY = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    uart_tx_frame_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    function automatic logic next_parity(input logic acc, input logic sent_bit);
        return acc ^ sent_bit;
    endfunction

    function automatic logic parity_bit(input logic acc, input logic odd);
        return acc ^ odd;
    endfunction

    state_t     state_r;
    state_t     state_s;
    logic [7:0] hold_data_r;
    logic [7:0] hold_data_s;
    logic       hold_full_r;
    logic       hold_full_s;
    logic [7:0] shift_r;
    logic [7:0] shift_s;
    logic [3:0] cnt_r;
    logic [3:0] cnt_s;
    logic       par_acc_r;
    logic       par_acc_s;
    logic       bit8_r;
    logic       bit8_s;
    logic       par_en_r;
    logic       par_en_s;
    logic       odd_r;
    logic       odd_s;
    logic       tx_r;
    logic       tx_s;
    logic       tx_rdy_r;
    logic       tx_rdy_s;
    logic       tx_busy_r;
    logic       tx_busy_s;
    logic       load_s;
    logic       write_s;
    logic [3:0] data_len_s;

    // Frame FSM next state, shift path and registered line value.
    always_comb begin
        state_s    = state_r;
        shift_s    = shift_r;
        cnt_s      = cnt_r;
        par_acc_s  = par_acc_r;
        bit8_s     = bit8_r;
        par_en_s   = par_en_r;
        odd_s      = odd_r;
        tx_s       = tx_r;
        data_len_s = bit8_r ? 4'd8 : 4'd7;
        load_s     = bus.xmit_pulse & hold_full_r &
                     ((state_r == ST_IDLE) | (state_r == ST_STOP));

        if (load_s) begin
            // Configuration is captured here so mid-frame changes cannot corrupt the frame.
            shift_s   = hold_data_r;
            bit8_s    = bus.bit8;
            par_en_s  = bus.parity_en;
            odd_s     = bus.odd_n_even;
            par_acc_s = 1'b0;
            cnt_s     = 4'd0;
            state_s   = ST_START;
            tx_s      = 1'b0;
        end else if (bus.xmit_pulse) begin
            case (state_r)
                ST_IDLE: begin
                    tx_s = 1'b1;
                end
                ST_START: begin
                    tx_s      = shift_r[0];
                    shift_s   = {1'b0, shift_r[7:1]};
                    par_acc_s = next_parity(par_acc_r, shift_r[0]);
                    cnt_s     = 4'd1;
                    state_s   = ST_DATA;
                end
                ST_DATA: begin
                    if (cnt_r < data_len_s) begin
                        tx_s      = shift_r[0];
                        shift_s   = {1'b0, shift_r[7:1]};
                        par_acc_s = next_parity(par_acc_r, shift_r[0]);
                        cnt_s     = cnt_r + 4'd1;
                    end else if (par_en_r) begin
                        tx_s    = parity_bit(par_acc_r, odd_r);
                        state_s = ST_PARITY;
                    end else begin
                        tx_s    = 1'b1;
                        state_s = ST_STOP;
                    end
                end
                ST_PARITY: begin
                    tx_s    = 1'b1;
                    state_s = ST_STOP;
                end
                ST_STOP: begin
                    tx_s    = 1'b1;
                    state_s = ST_IDLE;
                end
                default: begin
                    tx_s    = 1'b1;
                    state_s = ST_IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Holding register write/drain and next status flags.
    always_comb begin
        write_s     = bus.data_en & ~hold_full_r;
        hold_data_s = hold_data_r;
        hold_full_s = hold_full_r;
        if (load_s) begin
            hold_full_s = 1'b0;
        end else if (write_s) begin
            hold_data_s = bus.tx_data;
            hold_full_s = 1'b1;
        end else begin
            hold_full_s = hold_full_r;
        end

        if (TXRDY_EARLY) begin
            tx_rdy_s = ~hold_full_s;
        end else begin
            tx_rdy_s = ~hold_full_s & (state_s == ST_IDLE);
        end
        tx_busy_s = (state_s != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            hold_data_r <= 8'h00;
            hold_full_r <= 1'b0;
            shift_r     <= 8'h00;
            cnt_r       <= 4'd0;
            par_acc_r   <= 1'b0;
            bit8_r      <= 1'b0;
            par_en_r    <= 1'b0;
            odd_r       <= 1'b0;
            tx_r        <= 1'b1;
            tx_rdy_r    <= 1'b1;
            tx_busy_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            hold_data_r <= hold_data_s;
            hold_full_r <= hold_full_s;
            shift_r     <= shift_s;
            cnt_r       <= cnt_s;
            par_acc_r   <= par_acc_s;
            bit8_r      <= bit8_s;
            par_en_r    <= par_en_s;
            odd_r       <= odd_s;
            tx_r        <= tx_s;
            tx_rdy_r    <= tx_rdy_s;
            tx_busy_r   <= tx_busy_s;
        end
    end

    assign bus.tx      = tx_r;
    assign bus.tx_rdy  = tx_rdy_r;
    assign bus.tx_busy = tx_busy_r;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: bit-by-bit line checks at each xmit_pulse against hand-derived frames.
module tb_uart_tx_frame;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;
    bit   pulse_en = 1'b0;
    int   div = 0;

    uart_tx_frame_if bus();

    uart_tx_frame #(.TXRDY_EARLY(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Baud strobe model: one-clk pulse every 16 clks, freezable through pulse_en.
    initial begin
        bus.xmit_pulse = 1'b0;
        forever begin
            @(negedge clk);
            if (pulse_en) begin
                div = (div == 15) ? 0 : div + 1;
                bus.xmit_pulse = (div == 0);
            end else begin
                bus.xmit_pulse = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, required finish before 1 ms");
        $fatal(1);
    end

    task automatic next_pulse();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk);
            if (bus.xmit_pulse === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL pulse_timeout: no xmit_pulse within 64 clk");
        end
    endtask

    task automatic do_write(input logic [7:0] d, input logic b8, input logic pe, input logic odd);
        @(negedge clk);
        bus.tx_data    = d;
        bus.bit8       = b8;
        bus.parity_en  = pe;
        bus.odd_n_even = odd;
        bus.data_en    = 1'b1;
        @(negedge clk);
        bus.data_en    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.tx_data = 8'h00;
        bus.data_en = 1'b0;
        bus.bit8 = 1'b1;
        bus.parity_en = 1'b0;
        bus.odd_n_even = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b want 1", bus.tx); end
        total++; if (bus.tx_rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy: got %b want 1", bus.tx_rdy); end
        total++; if (bus.tx_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.tx_busy); end
        @(negedge clk);
        reset = 1'b0;
        pulse_en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            next_pulse();
            total++; if (bus.tx !== 1'b1 || bus.tx_busy !== 1'b0) begin
                bad++; $display("FAIL idle_line[%0d]: got tx=%b busy=%b want tx=1 busy=0", k, bus.tx, bus.tx_busy);
            end
        end
    endtask

    task automatic test_8n1();
        logic [9:0] exp_bits;
        exp_bits = 10'b0_10101010_1;
        do_write(8'h55, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            next_pulse();
            total++; if (bus.tx !== exp_bits[9-k]) begin
                bad++; $display("FAIL frame_55[%0d]: got %b want %b", k, bus.tx, exp_bits[9-k]);
            end
            if (k == 0) begin
                total++; if (bus.tx_busy !== 1'b1) begin bad++; $display("FAIL busy_55: got %b want 1", bus.tx_busy); end
            end
        end
        next_pulse();
        total++; if (bus.tx !== 1'b1 || bus.tx_busy !== 1'b0) begin
            bad++; $display("FAIL end_55: got tx=%b busy=%b want tx=1 busy=0", bus.tx, bus.tx_busy);
        end
    endtask

    task automatic test_parity_even();
        logic [9:0] exp_bits;
        exp_bits = 10'b0_1000001_0_1;
        do_write(8'hC1, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 10; k++) begin
            next_pulse();
            total++; if (bus.tx !== exp_bits[9-k]) begin
                bad++; $display("FAIL frame_7e1[%0d]: got %b want %b", k, bus.tx, exp_bits[9-k]);
            end
        end
        next_pulse();
        total++; if (bus.tx !== 1'b1 || bus.tx_busy !== 1'b0) begin
            bad++; $display("FAIL end_7e1: got tx=%b busy=%b want tx=1 busy=0", bus.tx, bus.tx_busy);
        end
    endtask

    task automatic test_parity_odd_toggle();
        logic [9:0] exp_bits;
        exp_bits = 10'b0_1000001_1_1;
        do_write(8'h41, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 10; k++) begin
            next_pulse();
            total++; if (bus.tx !== exp_bits[9-k]) begin
                bad++; $display("FAIL frame_7o1[%0d]: got %b want %b", k, bus.tx, exp_bits[9-k]);
            end
            if (k == 3) begin
                @(negedge clk);
                bus.odd_n_even = 1'b0;
                bus.parity_en  = 1'b0;
                bus.bit8       = 1'b1;
            end
        end
        next_pulse();
        total++; if (bus.tx !== 1'b1 || bus.tx_busy !== 1'b0) begin
            bad++; $display("FAIL end_7o1: got tx=%b busy=%b want tx=1 busy=0", bus.tx, bus.tx_busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] exp_bits;
        exp_bits = 20'b0_10100101_1_0_00111100_1;
        do_write(8'hA5, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            next_pulse();
            total++; if (bus.tx !== exp_bits[19-k]) begin
                bad++; $display("FAIL frame_b2b[%0d]: got %b want %b", k, bus.tx, exp_bits[19-k]);
            end
            if (k == 0) begin
                total++; if (bus.tx_rdy !== 1'b1) begin bad++; $display("FAIL rdy_after_load: got %b want 1", bus.tx_rdy); end
                do_write(8'h3C, 1'b1, 1'b0, 1'b0);
                total++; if (bus.tx_rdy !== 1'b0) begin bad++; $display("FAIL rdy_hold_full: got %b want 0", bus.tx_rdy); end
                do_write(8'hFF, 1'b1, 1'b0, 1'b0);
            end
        end
        next_pulse();
        total++; if (bus.tx !== 1'b1 || bus.tx_busy !== 1'b0 || bus.tx_rdy !== 1'b1) begin
            bad++; $display("FAIL end_b2b: got tx=%b busy=%b rdy=%b want 1 0 1", bus.tx, bus.tx_busy, bus.tx_rdy);
        end
    endtask

    task automatic test_reset_mid();
        logic [4:0]  pre_bits;
        logic [9:0]  exp_bits;
        pre_bits = 5'b0_1110;
        exp_bits = 10'b0_00000000_1;
        do_write(8'h07, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            next_pulse();
            total++; if (bus.tx !== pre_bits[4-k]) begin
                bad++; $display("FAIL frame_07[%0d]: got %b want %b", k, bus.tx, pre_bits[4-k]);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        total++; if (bus.tx !== 1'b1 || bus.tx_rdy !== 1'b1 || bus.tx_busy !== 1'b0) begin
            bad++; $display("FAIL abort: got tx=%b rdy=%b busy=%b want 1 1 0", bus.tx, bus.tx_rdy, bus.tx_busy);
        end
        @(negedge clk);
        reset = 1'b0;
        next_pulse();
        total++; if (bus.tx !== 1'b1 || bus.tx_busy !== 1'b0) begin
            bad++; $display("FAIL after_abort: got tx=%b busy=%b want tx=1 busy=0", bus.tx, bus.tx_busy);
        end
        do_write(8'h00, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            next_pulse();
            total++; if (bus.tx !== exp_bits[9-k]) begin
                bad++; $display("FAIL frame_00[%0d]: got %b want %b", k, bus.tx, exp_bits[9-k]);
            end
        end
        next_pulse();
        total++; if (bus.tx !== 1'b1 || bus.tx_busy !== 1'b0) begin
            bad++; $display("FAIL end_00: got tx=%b busy=%b want tx=1 busy=0", bus.tx, bus.tx_busy);
        end
    endtask

    task automatic test_pulse_hold();
        logic [9:0] exp_bits;
        exp_bits = 10'b0_11001100_1;
        do_write(8'h33, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            next_pulse();
            total++; if (bus.tx !== exp_bits[9-k]) begin
                bad++; $display("FAIL frame_33[%0d]: got %b want %b", k, bus.tx, exp_bits[9-k]);
            end
            if (k == 3) begin
                @(negedge clk);
                pulse_en = 1'b0;
                for (int i = 0; i < 100; i++) begin
                    @(negedge clk);
                    if (i % 25 == 24) begin
                        total++; if (bus.tx !== 1'b0 || bus.tx_busy !== 1'b1) begin
                            bad++; $display("FAIL stall[%0d]: got tx=%b busy=%b want tx=0 busy=1", i, bus.tx, bus.tx_busy);
                        end
                    end
                end
                pulse_en = 1'b1;
            end
        end
        next_pulse();
        total++; if (bus.tx !== 1'b1 || bus.tx_busy !== 1'b0) begin
            bad++; $display("FAIL end_33: got tx=%b busy=%b want tx=1 busy=0", bus.tx, bus.tx_busy);
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity_even();
        test_parity_odd_toggle();
        test_back_to_back();
        test_reset_mid();
        test_pulse_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
